// File: rtl/systolic_pkg.sv
// Shared definitions for the matrix skewer and deskewer around the systolic array.
// Wavefront geometry helpers and the deskew state encoding.
package systolic_pkg;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // Number of beats in one skewed frame of a size x size matrix.
   function automatic int beat_count(input int size);
      return 2 * size - 1;
   endfunction

   // Lane t of beat b carries a real element (not padding) when 0 <= b-t < size.
   function automatic logic lane_in_range(input int b, input int t, input int size);
      return (b >= t) && ((b - t) < size);
   endfunction

endpackage

// File: rtl/deskew_beat_counter.sv
// Modulo-(2*SIZE-1) beat counter; last flags the final beat of a frame.
module deskew_beat_counter
   import systolic_pkg::*;
#(
   parameter int SIZE = 3,
   parameter int CNTW = $clog2(beat_count(SIZE))
) (
   input  logic            clock,
   input  logic            nreset,
   input  logic            clr_i,
   input  logic            inc_i,
   output logic [CNTW-1:0] cnt_o,
   output logic            last_o
);

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(beat_count(SIZE) - 1);

   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;

   // Next count: clear wins, wrap after the last beat.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNTW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/deskew_matrix.sv
// Reassembles a SIZE x SIZE matrix from a skewed wavefront stream of 2*SIZE-1 beats
// and presents it with a valid/ready handshake.
module deskew_matrix
   import systolic_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int SIZE  = 3,
   parameter int CNTW  = $clog2(2 * SIZE - 1)
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIZE*WIDTH-1:0] in_beat,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      Mout [SIZE-1:0][SIZE-1:0],
   output logic                  pad_error,
   output logic [CNTW-1:0]       beat_cnt
);

   state_t          state_q;
   logic            out_valid_q;
   logic            pad_error_q;
   logic [WIDTH-1:0] mout_q [SIZE-1:0][SIZE-1:0];
   logic [CNTW-1:0] cnt_s;
   logic            last_s;
   logic            accept_s;
   logic            pad_s;

   assign in_ready = (state_q == COLLECT) && !clear;
   assign accept_s = in_valid && in_ready;

   deskew_beat_counter #(
      .SIZE (SIZE),
      .CNTW (CNTW)
   ) u_cnt (
      .clock  (clock),
      .nreset (nreset),
      .clr_i  (clear),
      .inc_i  (accept_s),
      .cnt_o  (cnt_s),
      .last_o (last_s)
   );

   // Any lane that should be padding for the current beat index but is nonzero.
   always_comb begin
      pad_s = 1'b0;
      for (int t = 0; t < SIZE; t++) begin
         if (!lane_in_range(int'(cnt_s), t, SIZE) && (in_beat[WIDTH*t +: WIDTH] != '0)) begin
            pad_s = 1'b1;
         end else begin
            pad_s = pad_s;
         end
      end
   end

   // Frame control: collect beats, then hold the matrix until consumed.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q     <= COLLECT;
         out_valid_q <= 1'b0;
         pad_error_q <= 1'b0;
      end else if (clear) begin
         state_q     <= COLLECT;
         out_valid_q <= 1'b0;
         pad_error_q <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (accept_s) begin
                  pad_error_q <= (cnt_s == '0) ? pad_s : (pad_error_q | pad_s);
                  if (last_s) begin
                     state_q     <= HOLD;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q     <= COLLECT;
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= COLLECT;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Element [r][c] arrives on lane SIZE-1-r of beat c+SIZE-1-r; nothing else writes it.
   for (genvar r = 0; r < SIZE; r++) begin : g_row
      for (genvar c = 0; c < SIZE; c++) begin : g_col
         localparam int LANE = SIZE - 1 - r;
         localparam logic [CNTW-1:0] BEAT = CNTW'(c + LANE);

         always_ff @(posedge clock or negedge nreset) begin
            if (!nreset) begin
               mout_q[r][c] <= '0;
            end else if (accept_s && (cnt_s == BEAT)) begin
               mout_q[r][c] <= in_beat[WIDTH*LANE +: WIDTH];
            end
         end

         assign Mout[r][c] = mout_q[r][c];
      end
   end

   assign out_valid = out_valid_q;
   assign pad_error = pad_error_q;
   assign beat_cnt  = cnt_s;

endmodule

// File: tb/tb_deskew_matrix.sv
// Directed bench for deskew_matrix (WIDTH=4, SIZE=3) with hand-computed beats and matrices.
module tb_deskew_matrix;

   logic        clock;
   logic        nreset;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_beat;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  Mout [2:0][2:0];
   logic        pad_error;
   logic [2:0]  beat_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Rows {1,2,3},{7,6,5},{8,9,4} and its transpose, packed row-major from [0][0].
   localparam logic [35:0] MAT_A  = 36'h123765894;
   localparam logic [35:0] MAT_AT = 36'h178269354;
   localparam logic [35:0] MAT_0  = 36'h000000000;

   deskew_matrix #(.WIDTH(4), .SIZE(3)) dut (
      .clock     (clock),
      .nreset    (nreset),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_beat   (in_beat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Mout      (Mout),
      .pad_error (pad_error),
      .beat_cnt  (beat_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_mat(input string tag, input logic [35:0] exp);
      logic [35:0] obs;
      obs = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            obs[(8 - (r*3 + c))*4 +: 4] = Mout[r][c];
         end
      end
      check(tag, obs, exp);
   endtask

   task automatic send_beat(input logic [11:0] b);
      in_valid = 1'b1;
      in_beat  = b;
      @(negedge clock);
      in_valid = 1'b0;
      in_beat  = 12'h000;
   endtask

   task automatic send_frame(input string tag, input logic [11:0] b0, input logic [11:0] b1,
                             input logic [11:0] b2, input logic [11:0] b3, input logic [11:0] b4);
      logic [11:0] bs [5];
      bs = '{b0, b1, b2, b3, b4};
      for (int i = 0; i < 5; i++) begin
         check({tag, " cnt"}, 36'(beat_cnt), 36'(i));
         check({tag, " valid low"}, 36'(out_valid), 36'h0);
         in_valid = 1'b1;
         in_beat  = bs[i];
         @(negedge clock);
      end
      in_valid = 1'b0;
      in_beat  = 12'h000;
      check({tag, " valid high"}, 36'(out_valid), 36'h1);
      check({tag, " ready low"}, 36'(in_ready), 36'h0);
      check({tag, " cnt wrap"}, 36'(beat_cnt), 36'h0);
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check({tag, " valid fall"}, 36'(out_valid), 36'h0);
      check({tag, " ready back"}, 36'(in_ready), 36'h1);
   endtask

   initial begin
      nreset    = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_beat   = 12'h000;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("rst valid", 36'(out_valid), 36'h0);
      check("rst pad", 36'(pad_error), 36'h0);
      check("rst cnt", 36'(beat_cnt), 36'h0);
      check_mat("rst mout", MAT_0);
      nreset = 1'b1;
      @(negedge clock);
      check("rst ready", 36'(in_ready), 36'h1);

      // Back-to-back frame, then hold four cycles before consuming.
      send_frame("f1", 12'h008, 12'h079, 12'h164, 12'h250, 12'h300);
      check_mat("f1 mout", MAT_A);
      check("f1 pad", 36'(pad_error), 36'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("hold valid", 36'(out_valid), 36'h1);
         check("hold ready", 36'(in_ready), 36'h0);
         check_mat("hold mout", MAT_A);
      end
      consume("f1");

      // Transposed matrix.
      send_frame("f2", 12'h003, 12'h025, 12'h164, 12'h790, 12'h800);
      check_mat("f2 mout", MAT_AT);
      consume("f2");

      // in_valid gap of three cycles between beats 1 and 2.
      send_beat(12'h008);
      send_beat(12'h079);
      for (int i = 0; i < 3; i++) begin
         check("gap cnt", 36'(beat_cnt), 36'h2);
         @(negedge clock);
      end
      send_beat(12'h164);
      send_beat(12'h250);
      check("gap valid low", 36'(out_valid), 36'h0);
      send_beat(12'h300);
      check("gap valid", 36'(out_valid), 36'h1);
      check_mat("gap mout", MAT_A);
      consume("gap");

      // Nonzero padding on lane 2 of beat 0.
      send_frame("pad", 12'h108, 12'h079, 12'h164, 12'h250, 12'h300);
      check("pad err", 36'(pad_error), 36'h1);
      check_mat("pad mout", MAT_A);
      check("pad m20", 36'(Mout[2][0]), 36'h8);
      consume("pad");
      send_frame("clean", 12'h003, 12'h025, 12'h164, 12'h790, 12'h800);
      check("clean pad", 36'(pad_error), 36'h0);
      check_mat("clean mout", MAT_AT);
      consume("clean");

      // Abort after beat 2; the beat offered with clear is dropped.
      send_beat(12'h108);
      send_beat(12'h079);
      send_beat(12'h164);
      check("abort pad set", 36'(pad_error), 36'h1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_beat  = 12'h250;
      #1;
      check("clear ready", 36'(in_ready), 36'h0);
      @(negedge clock);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clear cnt", 36'(beat_cnt), 36'h0);
      check("clear pad", 36'(pad_error), 36'h0);
      check("clear valid", 36'(out_valid), 36'h0);
      send_frame("post clr", 12'h003, 12'h025, 12'h164, 12'h790, 12'h800);
      check_mat("post clr mout", MAT_AT);
      check("post clr pad", 36'(pad_error), 36'h0);
      consume("post clr");

      // Asynchronous reset mid-frame.
      send_beat(12'h108);
      send_beat(12'h079);
      #2 nreset = 1'b0;
      #1;
      check("arst cnt", 36'(beat_cnt), 36'h0);
      check("arst pad", 36'(pad_error), 36'h0);
      check_mat("arst mout", MAT_0);
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);
      send_frame("post arst", 12'h008, 12'h079, 12'h164, 12'h250, 12'h300);
      check_mat("post arst mout", MAT_A);

      // Asynchronous reset during HOLD.
      #2 nreset = 1'b0;
      #1;
      check("hrst valid", 36'(out_valid), 36'h0);
      check("hrst pad", 36'(pad_error), 36'h0);
      check_mat("hrst mout", MAT_0);
      @(negedge clock);
      nreset = 1'b1;
      @(negedge clock);
      send_frame("final", 12'h003, 12'h025, 12'h164, 12'h790, 12'h800);
      check_mat("final mout", MAT_AT);
      consume("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/deskew_matrix.md
Name: deskew_matrix

Overview:
- Receive-side counterpart of the matrix skew/expander feeding the systolic array.
- Accepts a skewed wavefront stream of 2*SIZE-1 beats, each SIZE*WIDTH bits wide, and reassembles the original SIZE x SIZE matrix.
- Presents the matrix with a valid/ready handshake.
- Sits at the systolic array boundary and in loopback benches against the skewer.

Parameters:
- WIDTH, 4, element width in bits.
- SIZE, 3, matrix dimension (SIZE >= 2).

Ports:
- clock  in  1  single clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  beat present on in_beat.
- in_ready  out  1  block can accept a beat.
- in_beat  in  SIZE*WIDTH  skewed beat; lane t = bits [WIDTH*(t+1)-1 : WIDTH*t].
- out_valid  out  1  Mout holds a complete frame.
- out_ready  in  1  consumer takes Mout.
- Mout  out  WIDTH x [SIZE-1:0][SIZE-1:0] unpacked  reassembled matrix, Mout[row][col].
- pad_error  out  1  a padding lane of the current/held frame was nonzero.
- beat_cnt  out  CNTW  beats accepted in current frame; CNTW = $clog2(2*SIZE-1).

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low (nreset).
- Reset values:
  - State COLLECT, beat_cnt=0, out_valid=0, pad_error=0.
  - All Mout elements 0. in_ready=1 after reset release.
- Stream mapping (frame of beats b=0..2*SIZE-2):
  - Lane t of beat b carries Min[SIZE-1-t][b-t] when 0 <= b-t < SIZE, else padding (must be 0).
  - Reassembly rule: Mout[SIZE-1-t][b-t] <= lane t of beat b.
- Beat acceptance: a beat is accepted when in_valid & in_ready on a rising edge.
- in_ready = (state==COLLECT) & !clear.
- COLLECT state:
  - On accept: write every in-range lane into Mout; beat_cnt++.
  - If beat_cnt == 2*SIZE-2 at accept: beat_cnt->0, state->HOLD, out_valid->1 next cycle.
  - Out-of-range lanes are never written.
- HOLD state:
  - out_valid=1; Mout and pad_error held stable; in_ready=0.
  - On out_ready=1: out_valid->0, state->COLLECT next cycle.
  - There is no same-cycle restart, so there is always one bubble between frames.
- Latency and throughput:
  - out_valid rises the cycle after the last beat is accepted.
  - Minimum frame period is 2*SIZE cycles.
- pad_error:
  - On accepting beat 0, load with (any padding lane of beat 0 nonzero).
  - On later beats, OR in that beat's padding check.
  - Held through HOLD. Data is still reassembled when it is set.
- Mout contents:
  - Not cleared between frames; each frame overwrites all SIZE*SIZE positions.
  - Visible intermediate values during COLLECT are don't-care to consumers.
- in_valid gaps: beat_cnt holds. There is no timeout.
- clear (synchronous, highest priority after nreset):
  - Next state COLLECT, beat_cnt=0, out_valid=0, pad_error=0. Mout retained.
  - A beat presented in the clear cycle is dropped (in_ready=0).
- nreset mid-frame: immediate return to reset values. A partial frame is discarded.
- Simultaneous out_ready and clear: clear wins; the frame counts as consumed.

Decomposition:
- Package systolic_pkg:
  - beat_count(SIZE) = 2*SIZE-1.
  - lane_in_range(b,t,SIZE) function.
  - state enum {COLLECT, HOLD}.
  - Shared by the skewer and this block.
- One sub-module: deskew_beat_counter.
  - Modulo-(2*SIZE-1) counter with inc, clr and last outputs.
- The lane-write generate loop stays in the top module.

Test Plan (WIDTH=4, SIZE=3; source matrix rows {1,2,3},{7,6,5},{8,9,4}):
1. Back-to-back beats 12'h008, 12'h079, 12'h164, 12'h250, 12'h300 with out_ready=0 -> out_valid rises the cycle after beat 4; Mout rows {1,2,3},{7,6,5},{8,9,4}; pad_error=0; in_ready=0 while held.
2. Same frame with in_valid dropped for 3 cycles between beats 1 and 2 -> identical Mout; beat_cnt frozen at 2 during the gap.
3. Hold 4 cycles then pulse out_ready -> Mout stable across the hold; out_valid falls next cycle; in_ready=1 the cycle after; a second frame with a transposed matrix reassembles correctly.
4. Beat 0 = 12'h108 (lane 2 padding nonzero) -> frame completes with pad_error=1 and Mout[2][0]=8; the next clean frame shows pad_error=0.
5. clear asserted after beat 2, then a full clean frame -> no out_valid from the aborted frame; the clean frame reassembles correctly; beat_cnt was 0 after the clear.
6. nreset pulsed asynchronously mid-frame and during HOLD -> out_valid, pad_error and beat_cnt go to 0 immediately; Mout all zero; the next frame is correct.
